// File: rtl/snapshot_pair_streamer_pkg.sv
// Shared definitions for the snapshot pair streamer: FSM state encoding and
// the packed complex-sample width helper.
package snapshot_pair_streamer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_STREAM  = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // One complex sample is stored as {real, imag}.
   function automatic int cplx_width(input int data_width_bits);
      return 2 * data_width_bits;
   endfunction

endpackage

// File: rtl/snapshot_pair_streamer_buf.sv
// Snapshot buffer: single write port, combinational read, holds one channel's
// {real, imag} samples for a whole snapshot.
module snapshot_buf
   import snapshot_pair_streamer_pkg::*;
#(
   parameter int WIDTH     = cplx_width(12),
   parameter int DEPTH     = 64,
   parameter int ADDR_BITS = 6
) (
   input  logic                 i_clk,
   input  logic                 i_we,
   input  logic [ADDR_BITS-1:0] i_waddr,
   input  logic [WIDTH-1:0]     i_wdata,
   input  logic [ADDR_BITS-1:0] i_raddr,
   output logic [WIDTH-1:0]     o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // NOTE: the array has no reset on purpose; every entry is written during
   // CAPTURE before STREAM reads it, so resetting it would only add fan-out.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/snapshot_pair_streamer.sv
// Captures one snapshot of x/y complex sample pairs and replays it as two
// valid/ready/last streams for the correlator, then pulses o_done.
module snapshot_pair_streamer
   import snapshot_pair_streamer_pkg::*;
#(
   parameter int DATA_WIDTH_BITS = 12,
   parameter int SNAPSHOT_LEN    = 64,
   parameter int ADDR_BITS       = 6
) (
   input  logic                       i_clk,
   input  logic                       i_resetn,
   input  logic                       i_start,
   input  logic                       i_s_valid,
   input  logic [DATA_WIDTH_BITS-1:0] i_s_x_r,
   input  logic [DATA_WIDTH_BITS-1:0] i_s_x_c,
   input  logic [DATA_WIDTH_BITS-1:0] i_s_y_r,
   input  logic [DATA_WIDTH_BITS-1:0] i_s_y_c,
   output logic                       o_s_ready,
   output logic [DATA_WIDTH_BITS-1:0] o_x_r,
   output logic [DATA_WIDTH_BITS-1:0] o_x_c,
   output logic [DATA_WIDTH_BITS-1:0] o_y_r,
   output logic [DATA_WIDTH_BITS-1:0] o_y_c,
   output logic                       o_x_valid,
   output logic                       o_y_valid,
   output logic                       o_x_last,
   output logic                       o_y_last,
   input  logic                       i_ready_x,
   input  logic                       i_ready_y,
   output logic                       o_busy,
   output logic                       o_done
);

   localparam int                   CW        = cplx_width(DATA_WIDTH_BITS);
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SNAPSHOT_LEN - 1);

   state_t                     r_state, w_next_state;
   logic [ADDR_BITS-1:0]       r_wr_ptr, r_rd_ptr, w_raddr;
   logic                       r_acc_x, r_acc_y;
   logic [DATA_WIDTH_BITS-1:0] r_x_r, r_x_c, r_y_r, r_y_c;
   logic [CW-1:0]              w_x_rdata, w_y_rdata;
   logic                       w_wr_en, w_beat_done, w_enter_stream, w_load, w_clear;
   logic                       w_rd_at_last;

   snapshot_buf #(.WIDTH(CW), .DEPTH(SNAPSHOT_LEN), .ADDR_BITS(ADDR_BITS)) u_buf_x (
      .i_clk   (i_clk),
      .i_we    (w_wr_en),
      .i_waddr (r_wr_ptr),
      .i_wdata ({i_s_x_r, i_s_x_c}),
      .i_raddr (w_raddr),
      .o_rdata (w_x_rdata)
   );

   snapshot_buf #(.WIDTH(CW), .DEPTH(SNAPSHOT_LEN), .ADDR_BITS(ADDR_BITS)) u_buf_y (
      .i_clk   (i_clk),
      .i_we    (w_wr_en),
      .i_waddr (r_wr_ptr),
      .i_wdata ({i_s_y_r, i_s_y_c}),
      .i_raddr (w_raddr),
      .o_rdata (w_y_rdata)
   );

   assign w_rd_at_last = (r_rd_ptr == LAST_ADDR);

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      o_s_ready    = 1'b0;
      o_busy       = 1'b1;
      o_done       = 1'b0;
      w_wr_en      = 1'b0;
      w_beat_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_busy = 1'b0;
            if (i_start) w_next_state = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            o_s_ready = 1'b1;
            w_wr_en   = i_s_valid;
            if (i_s_valid && r_wr_ptr == LAST_ADDR) w_next_state = ST_STREAM;
         end
         ST_STREAM: begin
            // A channel already accepted no longer waits on its ready.
            w_beat_done = (r_acc_x | i_ready_x) & (r_acc_y | i_ready_y);
            if (w_beat_done && w_rd_at_last) w_next_state = ST_DONE;
         end
         ST_DONE: begin
            o_done       = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   assign w_enter_stream = (r_state == ST_CAPTURE) && (w_next_state == ST_STREAM);
   assign w_load         = w_enter_stream | (w_beat_done & ~w_rd_at_last);
   assign w_clear        = w_beat_done & w_rd_at_last;
   assign w_raddr        = (r_state == ST_CAPTURE) ? '0 : r_rd_ptr + 1'b1;

   assign o_x_valid = (r_state == ST_STREAM) & ~r_acc_x;
   assign o_y_valid = (r_state == ST_STREAM) & ~r_acc_y;
   assign o_x_last  = o_x_valid & w_rd_at_last;
   assign o_y_last  = o_y_valid & w_rd_at_last;
   assign o_x_r     = r_x_r;
   assign o_x_c     = r_x_c;
   assign o_y_r     = r_y_r;
   assign o_y_c     = r_y_c;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_acc_x  <= 1'b0;
         r_acc_y  <= 1'b0;
         r_x_r    <= '0;
         r_x_c    <= '0;
         r_y_r    <= '0;
         r_y_c    <= '0;
      end else begin
         if (r_state == ST_IDLE && i_start) r_wr_ptr <= '0;
         else if (w_wr_en)                  r_wr_ptr <= r_wr_ptr + 1'b1;

         if (w_enter_stream)                     r_rd_ptr <= '0;
         else if (w_beat_done && !w_rd_at_last)  r_rd_ptr <= r_rd_ptr + 1'b1;

         if (w_beat_done)                  r_acc_x <= 1'b0;
         else if (o_x_valid && i_ready_x)  r_acc_x <= 1'b1;

         if (w_beat_done)                  r_acc_y <= 1'b0;
         else if (o_y_valid && i_ready_y)  r_acc_y <= 1'b1;

         // Data returns to zero after the final beat so IDLE/DONE present zeros.
         if (w_load) begin
            {r_x_r, r_x_c} <= w_x_rdata;
            {r_y_r, r_y_c} <= w_y_rdata;
         end else if (w_clear) begin
            r_x_r <= '0;
            r_x_c <= '0;
            r_y_r <= '0;
            r_y_c <= '0;
         end
      end
   end

endmodule

// File: tb/tb_snapshot_pair_streamer.sv
// Scoreboard bench: stimulus pushes expected beats per channel, a negedge
// monitor pops and compares on every accepted beat.
module tb_snapshot_pair_streamer;

   localparam int DW  = 12;
   localparam int LEN = 4;
   localparam int AB  = 2;

   typedef logic [2*DW:0] beat_t;  // {last, real, imag}

   logic          i_clk = 1'b0;
   logic          i_resetn, i_start, i_s_valid;
   logic [DW-1:0] i_s_x_r, i_s_x_c, i_s_y_r, i_s_y_c;
   logic          o_s_ready;
   logic [DW-1:0] o_x_r, o_x_c, o_y_r, o_y_c;
   logic          o_x_valid, o_y_valid, o_x_last, o_y_last;
   logic          i_ready_x, i_ready_y, o_busy, o_done;

   int    n_checks = 0;
   int    n_fail   = 0;
   beat_t exp_x[$];
   beat_t exp_y[$];
   int    pops_x = 0, pops_y = 0, done_seen = 0;
   logic  mx_acc = 0, my_acc = 0, x_fin = 0, y_fin = 0, done_due = 0;
   logic  prev_xv = 0, prev_xr = 0, prev_yv = 0, prev_yr = 0;
   beat_t prev_xb, prev_yb;

   always #5 i_clk = ~i_clk;

   snapshot_pair_streamer #(.DATA_WIDTH_BITS(DW), .SNAPSHOT_LEN(LEN), .ADDR_BITS(AB)) dut (
      .i_clk     (i_clk),
      .i_resetn  (i_resetn),
      .i_start   (i_start),
      .i_s_valid (i_s_valid),
      .i_s_x_r   (i_s_x_r),
      .i_s_x_c   (i_s_x_c),
      .i_s_y_r   (i_s_y_r),
      .i_s_y_c   (i_s_y_c),
      .o_s_ready (o_s_ready),
      .o_x_r     (o_x_r),
      .o_x_c     (o_x_c),
      .o_y_r     (o_y_r),
      .o_y_c     (o_y_c),
      .o_x_valid (o_x_valid),
      .o_y_valid (o_y_valid),
      .o_x_last  (o_x_last),
      .o_y_last  (o_y_last),
      .i_ready_x (i_ready_x),
      .i_ready_y (i_ready_y),
      .o_busy    (o_busy),
      .o_done    (o_done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({o_s_ready, o_x_valid, o_y_valid, o_x_last, o_y_last, o_busy, o_done,
                  o_x_r, o_x_c, o_y_r, o_y_c});
   endfunction

   // Monitor: the model is "beats leave in capture order; a beat finishes once
   // both channels have taken it; done follows the final beat by one cycle".
   always @(negedge i_clk) begin
      beat_t e;
      if (!i_resetn) begin
         exp_x.delete();
         exp_y.delete();
         mx_acc = 0; my_acc = 0; x_fin = 0; y_fin = 0; done_due = 0;
         prev_xv = 0; prev_yv = 0; prev_xr = 0; prev_yr = 0;
      end else begin
         if (o_done || done_due) check("done_timing", 64'(o_done), 64'(done_due));
         if (o_done) done_seen++;

         if (mx_acc) check("x_valid_drop", 64'(o_x_valid), 64'd0);
         if (my_acc) check("y_valid_drop", 64'(o_y_valid), 64'd0);
         if (prev_xv && !prev_xr) begin
            check("x_hold_valid", 64'(o_x_valid), 64'd1);
            check("x_hold_data", 64'({o_x_last, o_x_r, o_x_c}), 64'(prev_xb));
         end
         if (prev_yv && !prev_yr) begin
            check("y_hold_valid", 64'(o_y_valid), 64'd1);
            check("y_hold_data", 64'({o_y_last, o_y_r, o_y_c}), 64'(prev_yb));
         end

         if (o_x_valid && i_ready_x) begin
            if (exp_x.size() == 0) check("x_beat_expected", 64'(exp_x.size()), 64'd1);
            else begin
               e = exp_x.pop_front();
               check("x_beat", 64'({o_x_last, o_x_r, o_x_c}), 64'(e));
               if (e[2*DW]) x_fin = 1;
            end
            pops_x++;
            mx_acc = 1;
         end
         if (o_y_valid && i_ready_y) begin
            if (exp_y.size() == 0) check("y_beat_expected", 64'(exp_y.size()), 64'd1);
            else begin
               e = exp_y.pop_front();
               check("y_beat", 64'({o_y_last, o_y_r, o_y_c}), 64'(e));
               if (e[2*DW]) y_fin = 1;
            end
            pops_y++;
            my_acc = 1;
         end
         if (mx_acc && my_acc) begin
            mx_acc = 0;
            my_acc = 0;
         end
         done_due = x_fin && y_fin;
         if (done_due) begin
            x_fin = 0;
            y_fin = 0;
         end

         prev_xv = o_x_valid; prev_xr = i_ready_x; prev_xb = {o_x_last, o_x_r, o_x_c};
         prev_yv = o_y_valid; prev_yr = i_ready_y; prev_yb = {o_y_last, o_y_r, o_y_c};
      end
   end

   // gap_kind: 0 none, 1 fixed 1,0,0,1,1,0,1 pattern, 2 random.
   // rmode: 0 both ready, 1 random, 2 y lags x by 3 cycles, 3 ten-cycle stall.
   task automatic run_snapshot(input int gap_kind, input int rmode, input bit ign,
                               input bit fixed_data, input bit abort);
      int  pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      int  n, idx, d0, bx, by, done_cyc;
      bit  v, got;
      logic [DW-1:0] xr, xc, yr, yc;

      d0 = done_seen;
      @(posedge i_clk); #1;
      i_start = 1'b1;
      @(negedge i_clk);
      check("ready_before_start", 64'(o_s_ready), 64'd0);
      @(posedge i_clk); #1;
      i_start = 1'b0;
      @(negedge i_clk);
      check("start_latency", 64'({o_s_ready, o_busy}), 64'b11);

      n = 0;
      idx = 0;
      while (n < LEN) begin
         @(posedge i_clk); #1;
         case (gap_kind)
            0:       v = 1'b1;
            1:       v = pat[idx % 7] != 0;
            default: v = $urandom_range(0, 1) != 0;
         endcase
         idx++;
         if (fixed_data) begin
            xr = DW'(n); xc = DW'(-n); yr = DW'(2 * n); yc = DW'(3 * n);
         end else begin
            xr = DW'($urandom); xc = DW'($urandom); yr = DW'($urandom); yc = DW'($urandom);
         end
         if (v) begin
            exp_x.push_back({n == LEN - 1, xr, xc});
            exp_y.push_back({n == LEN - 1, yr, yc});
         end
         i_s_valid = v;
         i_s_x_r = xr; i_s_x_c = xc; i_s_y_r = yr; i_s_y_c = yc;
         i_start   = ign && idx == 2;
         i_ready_x = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         i_ready_y = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge i_clk);
         check("capture_ready", 64'({o_s_ready, o_x_valid}), 64'b10);
         if (v) n++;
      end
      @(posedge i_clk); #1;
      i_s_valid = 1'b0;
      i_start   = 1'b0;
      @(negedge i_clk);
      check("stream_start", 64'({o_s_ready, o_x_valid, o_y_valid}), 64'b011);

      bx = pops_x;
      by = pops_y;
      got = 0;
      done_cyc = -1;
      for (int c = 0; c < 400; c++) begin
         @(posedge i_clk); #1;
         if (abort && (pops_x - bx) >= 2 && (pops_y - by) >= 2) begin
            i_resetn = 1'b0;
            #1;
            check("abort_outputs", all_outs(), 64'd0);
            repeat (3) begin
               @(negedge i_clk);
               check("abort_no_done", 64'(o_done), 64'd0);
            end
            i_resetn = 1'b1;
            check("abort_done_count", 64'(done_seen - d0), 64'd0);
            return;
         end
         if (o_done) begin
            got = 1;
            done_cyc = c;
            break;
         end
         case (rmode)
            0: begin i_ready_x = 1'b1; i_ready_y = 1'b1; end
            1: begin i_ready_x = 1'($urandom_range(0, 1)); i_ready_y = 1'($urandom_range(0, 1)); end
            2: begin i_ready_x = 1'b1; i_ready_y = (c % 4) == 3; end
            default: begin
               i_ready_x = !(c >= 2 && c < 12);
               i_ready_y = !(c >= 2 && c < 12);
            end
         endcase
         i_start = ign && c == 1;
      end
      check("done_seen", 64'(got), 64'd1);
      if (rmode == 0) check("throughput", 64'(done_cyc), 64'(LEN - 1));

      i_start = ign;  // lands in DONE and on the DONE->IDLE edge
      @(posedge i_clk); #1;
      i_start = 1'b0;
      check("idle_after_done", all_outs(), 64'd0);
      @(posedge i_clk); #1;
      check("still_idle", 64'(o_busy), 64'd0);
      check("done_once", 64'(done_seen - d0), 64'd1);
      check("queues_drained", 64'(exp_x.size() + exp_y.size()), 64'd0);
      check("beat_count", 64'({16'(pops_x - bx), 16'(pops_y - by)}), 64'({16'(LEN), 16'(LEN)}));
   endtask

   initial begin
      i_resetn = 1'b0;
      i_start = 1'b0; i_s_valid = 1'b0;
      i_s_x_r = '0; i_s_x_c = '0; i_s_y_r = '0; i_s_y_c = '0;
      i_ready_x = 1'b0; i_ready_y = 1'b0;
      repeat (3) @(negedge i_clk);
      check("reset_outputs", all_outs(), 64'd0);
      i_resetn = 1'b1;

      run_snapshot(0, 0, 1'b0, 1'b1, 1'b0);  // basic throughput, known data
      run_snapshot(1, 0, 1'b0, 1'b0, 1'b0);  // capture gaps
      run_snapshot(0, 2, 1'b0, 1'b0, 1'b0);  // skewed ready
      run_snapshot(0, 3, 1'b0, 1'b0, 1'b0);  // stream stall
      run_snapshot(2, 1, 1'b1, 1'b0, 1'b0);  // ignored starts
      run_snapshot(0, 0, 1'b0, 1'b0, 1'b1);  // abort mid-stream
      run_snapshot(0, 0, 1'b0, 1'b0, 1'b0);  // clean snapshot after abort
      for (int i = 0; i < 12; i++) begin
         run_snapshot(2, 1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/snapshot_pair_streamer.md
Name: snapshot_pair_streamer

Overview:
- Upstream feeder for the correlation processor.
- Captures one snapshot of SNAPSHOT_LEN simultaneous complex sample pairs from two antenna channels (x, y) into internal buffers.
- Replays the snapshot as two AXI-stream-style channels with valid/ready/last, matching the correlator's x/y input ports, then reports completion.
- One snapshot in flight at a time. Capture and stream phases are strictly sequential.

Parameters:
- DATA_WIDTH_BITS, 12, width of each real/imag sample component (two's complement).
- SNAPSHOT_LEN, 64, sample pairs per snapshot; must be >= 2.
- ADDR_BITS, 6, buffer address width; must satisfy 2**ADDR_BITS >= SNAPSHOT_LEN.

Ports:
- i_clk  in  1  clock
- i_resetn  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle request to begin a snapshot; honoured only in IDLE
- i_s_valid  in  1  ADC pair valid
- i_s_x_r, i_s_x_c  in  DATA_WIDTH_BITS  channel x real/imag sample
- i_s_y_r, i_s_y_c  in  DATA_WIDTH_BITS  channel y real/imag sample
- o_s_ready  out  1  high while capturing
- o_x_r, o_x_c  out  DATA_WIDTH_BITS  x stream data
- o_y_r, o_y_c  out  DATA_WIDTH_BITS  y stream data
- o_x_valid, o_y_valid  out  1  per-channel stream valid
- o_x_last, o_y_last  out  1  high on beat SNAPSHOT_LEN-1
- i_ready_x, i_ready_y  in  1  per-channel downstream ready
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle pulse after the final beat is accepted on both channels

Behaviour:
- Reset (async assert, synchronous deassert handled externally):
  - state=IDLE; write pointer and read pointer = 0.
  - All o_* = 0, including data outputs.
  - Buffer contents undefined and never read before being written.
- States: IDLE, CAPTURE, STREAM, DONE.
- IDLE:
  - All outputs low.
  - i_start=1 -> CAPTURE next cycle, wr_ptr=0.
- CAPTURE:
  - o_s_ready=1.
  - Each cycle with i_s_valid=1 writes {x_r,x_c} and {y_r,y_c} at wr_ptr, then wr_ptr increments.
  - A write at wr_ptr=SNAPSHOT_LEN-1 -> STREAM next cycle.
  - On that same transition, output registers are loaded with entry 0 and rd_ptr=0. The buffer has combinational read, so there is no read bubble.
  - i_s_valid=0 stalls without limit.
  - i_start is ignored.
- STREAM:
  - o_x_valid=o_y_valid=1 until each channel's current beat is accepted.
  - Per-channel accepted flags acc_x and acc_y are set on valid&ready for that channel.
  - After a channel's acceptance, its valid drops, and stays low until the beat completes.
  - A beat completes in the cycle where (acc_x | i_ready_x) & (acc_y | i_ready_y) while the respective valids are high. Both channels accepting in the same cycle completes in one cycle.
  - On beat completion:
    - Flags clear.
    - If rd_ptr < SNAPSHOT_LEN-1: rd_ptr+1 and entry rd_ptr+1 are loaded into the output registers, and both valids are high next cycle. Full throughput is 1 beat/cycle when both readies are held high.
    - If rd_ptr = SNAPSHOT_LEN-1: -> DONE.
  - Data and last are held stable while the corresponding valid is high and unaccepted. Valid never depends combinationally on ready.
  - o_x_last = o_y_last = (rd_ptr == SNAPSHOT_LEN-1) & respective valid.
- DONE:
  - o_done=1 for exactly one cycle; o_busy still 1.
  - -> IDLE next cycle.
- Boundary cases:
  - i_start in DONE is ignored.
  - i_start in the same cycle DONE->IDLE is ignored; it is honoured from IDLE only.
  - Reset mid-CAPTURE or mid-STREAM aborts immediately. No o_done, no partial last.
  - i_ready_* high while valid is low has no effect.
- Latency: i_start to o_s_ready is 1 cycle. Last capture write to first o_x_valid is 1 cycle. Final beat acceptance to o_done is 1 cycle.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, CAPTURE=1, STREAM=2, DONE=3);
  - the complex-sample width helper 2*DATA_WIDTH_BITS.
- One natural sub-module: snapshot_buf, a single-write-port, combinational-read register array of width 2*DATA_WIDTH_BITS and depth SNAPSHOT_LEN. It is instantiated twice (x, y).
- The FSM, pointers and handshake flags live in the top module.

Test Plan:
- Basic throughput:
  - Stimulus: SNAPSHOT_LEN=4; i_start; samples x=(k, -k), y=(2k, 3k) for k=0..3 with i_s_valid held high; both readies high.
  - Response: o_s_ready high for 4 cycles; 4 consecutive stream beats with matching data; last only on k=3; o_done 1 cycle after beat 3.
- Capture gaps:
  - Stimulus: i_s_valid toggling 1,0,0,1,1,0,1.
  - Response: exactly 4 samples captured, in order; STREAM is entered only after the 4th write.
- Skewed ready:
  - Stimulus: i_ready_x high at beat 1, i_ready_y high 3 cycles later.
  - Response: o_x_valid drops after x acceptance; o_y data is held stable 3 cycles; beat 2 appears only after y accepts; no beat is duplicated or lost.
- Stream stall:
  - Stimulus: both readies low for 10 cycles at beat 2.
  - Response: data, valid and last are held stable; o_done still asserts exactly once.
- Ignored starts:
  - Stimulus: i_start pulsed during CAPTURE, STREAM and DONE.
  - Response: no restart; one o_done; IDLE reached; a new i_start afterwards begins a fresh capture at address 0.
- Abort:
  - Stimulus: i_resetn low at beat 2 of STREAM.
  - Response: all outputs 0 asynchronously; no o_done; after release, a full snapshot of new data streams correctly.
